// File: rtl/dvp_pattern_tx.sv
// OV7670-style DVP camera emulator: RGB565 test patterns, two bytes per pixel,
// with href/vsync framing and a completed-frame counter.
module dvp_pattern_tx #(
  parameter int H_ACTIVE   = 640,
  parameter int H_BLANK    = 144,
  parameter int V_SYNC     = 3,
  parameter int V_BACK     = 17,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int CHECK_LOG2 = 5
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [1:0]  i_pattern,
  input  logic [15:0] i_solid_rgb,
  output logic [7:0]  o_pixel,
  output logic        o_href,
  output logic        o_cam_vsync,
  output logic        o_frame_done,
  output logic [15:0] o_frame_count
);

  localparam int LINE_LEN = 2 * (H_ACTIVE + H_BLANK);
  localparam int BAR_W    = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1;

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  state_t              r_state;
  logic [15:0]         r_hcnt;
  logic [15:0]         r_vcnt;
  logic [1:0]          r_pattern;
  logic [15:0]         r_solid;

  logic [15:0]         w_lines;
  logic [15:0]         w_x;
  logic [15:0]         w_bar;
  logic [15:0]         w_rgb;
  logic [CHECK_LOG2:0] w_y;
  logic                w_line_end;
  logic                w_state_end;
  logic                w_href;
  logic [7:0]          w_byte;

  // Indices past 6 (including a wider remainder bar) all map to the final black bar.
  function automatic logic [15:0] bar_colour(input logic [15:0] idx);
    case (idx)
      16'd0:   bar_colour = 16'hFFFF;
      16'd1:   bar_colour = 16'hFFE0;
      16'd2:   bar_colour = 16'h07FF;
      16'd3:   bar_colour = 16'h07E0;
      16'd4:   bar_colour = 16'hF81F;
      16'd5:   bar_colour = 16'hF800;
      16'd6:   bar_colour = 16'h001F;
      default: bar_colour = 16'h0000;
    endcase
  endfunction

  always_comb begin
    w_lines = 16'd1;
    case (r_state)
      VSYNC:   w_lines = 16'(V_SYNC);
      VBACK:   w_lines = 16'(V_BACK);
      ACTIVE:  w_lines = 16'(V_ACTIVE);
      VFRONT:  w_lines = 16'(V_FRONT);
      default: w_lines = 16'd1;
    endcase
  end

  assign w_line_end  = (r_hcnt == 16'(LINE_LEN - 1));
  assign w_state_end = w_line_end && (r_vcnt == (w_lines - 16'd1));
  assign w_x         = {1'b0, r_hcnt[15:1]};
  assign w_y         = r_vcnt[CHECK_LOG2:0];
  assign w_bar       = w_x / 16'(BAR_W);
  assign w_href      = (r_state == ACTIVE) && (r_hcnt < 16'(2 * H_ACTIVE));

  always_comb begin
    w_rgb = 16'h0000;
    case (r_pattern)
      2'd0:    w_rgb = bar_colour(w_bar);
      2'd1:    w_rgb = {w_x[7:3], w_x[7:2], w_x[7:3]};
      2'd2:    w_rgb = (w_x[CHECK_LOG2] ^ w_y[CHECK_LOG2]) ? 16'hFFFF : 16'h0000;
      2'd3:    w_rgb = r_solid;
      default: w_rgb = 16'h0000;
    endcase
  end

  assign w_byte = r_hcnt[0] ? w_rgb[7:0] : w_rgb[15:8];

  // Outputs register the byte for the current counter position, so they trail the FSM by one edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_hcnt        <= 16'd0;
      r_vcnt        <= 16'd0;
      r_pattern     <= 2'd0;
      r_solid       <= 16'h0000;
      o_pixel       <= 8'h00;
      o_href        <= 1'b0;
      o_cam_vsync   <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_count <= 16'd0;
    end else begin
      o_href       <= w_href;
      o_pixel      <= w_href ? w_byte : 8'h00;
      o_cam_vsync  <= (r_state == VSYNC);
      o_frame_done <= (r_state == VFRONT) && w_state_end;
      if ((r_state == VFRONT) && w_state_end) begin
        o_frame_count <= o_frame_count + 16'd1;
      end

      case (r_state)
        IDLE: begin
          r_hcnt <= 16'd0;
          r_vcnt <= 16'd0;
          if (i_enable) begin
            r_state   <= VSYNC;
            r_pattern <= i_pattern;
            r_solid   <= i_solid_rgb;
          end
        end
        VSYNC, VBACK, ACTIVE, VFRONT: begin
          if (w_line_end) begin
            r_hcnt <= 16'd0;
            if (w_state_end) begin
              r_vcnt <= 16'd0;
              case (r_state)
                VSYNC:  r_state <= VBACK;
                VBACK:  r_state <= ACTIVE;
                ACTIVE: r_state <= VFRONT;
                default: begin
                  // End of frame: chain straight into the next one, relatching controls.
                  if (i_enable) begin
                    r_state   <= VSYNC;
                    r_pattern <= i_pattern;
                    r_solid   <= i_solid_rgb;
                  end else begin
                    r_state <= IDLE;
                  end
                end
              endcase
            end else begin
              r_vcnt <= r_vcnt + 16'd1;
            end
          end else begin
            r_hcnt <= r_hcnt + 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_hcnt  <= 16'd0;
          r_vcnt  <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Directed bench for dvp_pattern_tx with small framing (L=20, F=140):
// table of per-frame pattern vectors plus hand sequences for control corner cases.
module tb_dvp_pattern_tx;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  pattern;
  logic [15:0] solid_rgb;
  logic [7:0]  pixel;
  logic        href;
  logic        cam_vsync;
  logic        frame_done;
  logic [15:0] frame_count;

  int total = 0;
  int bad   = 0;

  dvp_pattern_tx #(
    .H_ACTIVE(8), .H_BLANK(2), .V_SYNC(1), .V_BACK(1),
    .V_ACTIVE(4), .V_FRONT(1), .CHECK_LOG2(1)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_pattern(pattern),
    .i_solid_rgb(solid_rgb), .o_pixel(pixel), .o_href(href),
    .o_cam_vsync(cam_vsync), .o_frame_done(frame_done), .o_frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] LN_BARS  = 128'hFFFF_FFE0_07FF_07E0_F81F_F800_001F_0000;
  localparam logic [127:0] LN_RAMP  = 128'h0000_0000_0000_0000_0020_0020_0020_0020;
  localparam logic [127:0] LN_CK0   = 128'h0000_0000_FFFF_FFFF_0000_0000_FFFF_FFFF;
  localparam logic [127:0] LN_CK2   = 128'hFFFF_FFFF_0000_0000_FFFF_FFFF_0000_0000;
  localparam logic [127:0] LN_S1234 = 128'h1234_1234_1234_1234_1234_1234_1234_1234;
  localparam logic [127:0] LN_SABCD = 128'hABCD_ABCD_ABCD_ABCD_ABCD_ABCD_ABCD_ABCD;
  localparam logic [127:0] LN_SF00F = 128'hF00F_F00F_F00F_F00F_F00F_F00F_F00F_F00F;

  typedef struct {
    logic [1:0]   pat1;
    logic [15:0]  sol1;
    logic [1:0]   pat2;
    logic [15:0]  sol2;
    logic [511:0] exp1;
    logic [511:0] exp2;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Captures one frame starting at the vsync rise; at c=60 (mid ACTIVE) drives new controls.
  task automatic capture_frame(input string tag, input int fnum, input logic [511:0] exp,
                               input logic [1:0] pat2, input logic [15:0] sol2,
                               input logic en2, output int waited);
    int vs_in, vs_out, hr_n, hr_bad, px_bad, first_hr, fd_n, fd_at;
    int ln, p;
    logic [15:0]  fc_at_done;
    logic [127:0] cap [4];
    vs_in = 0; vs_out = 0; hr_n = 0; hr_bad = 0; px_bad = 0;
    first_hr = -1; fd_n = 0; fd_at = -1; fc_at_done = 16'hDEAD;
    for (int i = 0; i < 4; i++) cap[i] = 128'h0;
    waited = 0;
    while (!cam_vsync && waited < 30) begin
      tick();
      waited++;
    end
    check({tag, "_vsync_seen"}, 128'(cam_vsync), 128'd1);
    for (int c = 0; c < 140; c++) begin
      if (cam_vsync) begin
        if (c < 20) vs_in++;
        else vs_out++;
      end
      if (!href && pixel != 8'h00) px_bad++;
      if (href) begin
        hr_n++;
        if (first_hr < 0) first_hr = c;
      end
      if (c >= 40 && c < 120) begin
        ln = (c - 40) / 20;
        p  = (c - 40) % 20;
        if (p < 16) begin
          if (href) cap[ln][(15 - p) * 8 +: 8] = pixel;
          else hr_bad++;
        end else if (href) begin
          hr_bad++;
        end
      end else if (href) begin
        hr_bad++;
      end
      if (frame_done) begin
        fd_n++;
        fd_at = c;
        fc_at_done = frame_count;
      end
      if (c == 60) begin
        pattern   = pat2;
        solid_rgb = sol2;
        enable    = en2;
      end
      tick();
    end
    check({tag, "_vsync_len"}, 128'(vs_in), 128'd20);
    check({tag, "_vsync_extra"}, 128'(vs_out), 128'd0);
    check({tag, "_first_href"}, 128'(first_hr), 128'd40);
    check({tag, "_href_bytes"}, 128'(hr_n), 128'd64);
    check({tag, "_href_shape"}, 128'(hr_bad), 128'd0);
    check({tag, "_pixel_blank"}, 128'(px_bad), 128'd0);
    check({tag, "_done_pulses"}, 128'(fd_n), 128'd1);
    check({tag, "_done_cycle"}, 128'(fd_at), 128'd139);
    check({tag, "_frame_count"}, 128'(fc_at_done), 128'(fnum));
    for (int y = 0; y < 4; y++) begin
      check($sformatf("%s_line%0d", tag, y), cap[y], exp[(3 - y) * 128 +: 128]);
    end
  endtask

  initial begin
    int w;
    int viol;

    vecs[0] = '{2'd0, 16'h0000, 2'd1, 16'h0000,
                {LN_BARS, LN_BARS, LN_BARS, LN_BARS}, {LN_RAMP, LN_RAMP, LN_RAMP, LN_RAMP}};
    vecs[1] = '{2'd2, 16'h0000, 2'd2, 16'h0000,
                {LN_CK0, LN_CK0, LN_CK2, LN_CK2}, {LN_CK0, LN_CK0, LN_CK2, LN_CK2}};
    vecs[2] = '{2'd3, 16'h1234, 2'd3, 16'hABCD,
                {LN_S1234, LN_S1234, LN_S1234, LN_S1234}, {LN_SABCD, LN_SABCD, LN_SABCD, LN_SABCD}};
    vecs[3] = '{2'd3, 16'hF00F, 2'd2, 16'h0000,
                {LN_SF00F, LN_SF00F, LN_SF00F, LN_SF00F}, {LN_CK0, LN_CK0, LN_CK2, LN_CK2}};

    reset = 1'b1; enable = 1'b0; pattern = 2'd0; solid_rgb = 16'h0000;

    // Reset held with enable low, then released while still disabled.
    for (int i = 0; i < 50; i++) tick();
    check("rst_pixel", 128'(pixel), 128'd0);
    check("rst_href", 128'(href), 128'd0);
    check("rst_vsync", 128'(cam_vsync), 128'd0);
    check("rst_done", 128'(frame_done), 128'd0);
    check("rst_count", 128'(frame_count), 128'd0);
    reset = 1'b0;
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pixel != 8'h00 || href || cam_vsync || frame_done || frame_count != 16'd0) viol++;
    end
    check("idle_stays_quiet", 128'(viol), 128'd0);

    // Table: each entry runs two back-to-back frames, changing controls mid-frame.
    for (int v = 0; v < 4; v++) begin
      reset = 1'b1; enable = 1'b0;
      pattern = vecs[v].pat1; solid_rgb = vecs[v].sol1;
      tick();
      check($sformatf("v%0d_count_reset", v), 128'(frame_count), 128'd0);
      reset = 1'b0; enable = 1'b1;
      capture_frame($sformatf("v%0d_f1", v), 1, vecs[v].exp1, vecs[v].pat2, vecs[v].sol2, 1'b1, w);
      check($sformatf("v%0d_start_latency", v), 128'(w), 128'd2);
      capture_frame($sformatf("v%0d_f2", v), 2, vecs[v].exp2, vecs[v].pat2, vecs[v].sol2, 1'b1, w);
      check($sformatf("v%0d_b2b_gap", v), 128'(w), 128'd0);
      enable = 1'b0;
    end

    // Three continuous frames of colour bars; count must step 1, 2, 3 with no gap.
    reset = 1'b1; pattern = 2'd0; tick();
    reset = 1'b0; enable = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      capture_frame($sformatf("cont_f%0d", f), f,
                    {LN_BARS, LN_BARS, LN_BARS, LN_BARS}, 2'd0, 16'h0000, 1'b1, w);
      if (f > 1) check($sformatf("cont_gap%0d", f), 128'(w), 128'd0);
    end

    // Enable dropped mid-ACTIVE: frame finishes, then the block goes quiet.
    reset = 1'b1; enable = 1'b0; pattern = 2'd3; solid_rgb = 16'h1234; tick();
    reset = 1'b0; enable = 1'b1;
    capture_frame("drop", 1, {LN_S1234, LN_S1234, LN_S1234, LN_S1234}, 2'd3, 16'h1234, 1'b0, w);
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      if (pixel != 8'h00 || href || cam_vsync || frame_done) viol++;
      tick();
    end
    check("drop_idle_quiet", 128'(viol), 128'd0);
    check("drop_count_held", 128'(frame_count), 128'd1);

    // Reset asserted inside ACTIVE on an href byte.
    reset = 1'b1; tick();
    reset = 1'b0; enable = 1'b1; solid_rgb = 16'hABCD;
    w = 0;
    while (!cam_vsync && w < 30) begin
      tick();
      w++;
    end
    for (int i = 0; i < 50; i++) tick();
    check("mid_href_before", 128'(href), 128'd1);
    check("mid_pixel_before", 128'(pixel), 128'hAB);
    reset = 1'b1; enable = 1'b0;
    tick();
    check("mid_rst_pixel", 128'(pixel), 128'd0);
    check("mid_rst_href", 128'(href), 128'd0);
    check("mid_rst_vsync", 128'(cam_vsync), 128'd0);
    check("mid_rst_done", 128'(frame_done), 128'd0);
    check("mid_rst_count", 128'(frame_count), 128'd0);
    reset = 1'b0;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pixel != 8'h00 || href || cam_vsync || frame_done || frame_count != 16'd0) viol++;
    end
    check("mid_rst_idle", 128'(viol), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
